// File: rtl/rr_arb_mux41.sv
// Round-robin arbiter sharing one 4:1 mux channel between four requesters,
// with a per-grant transfer budget that only bites while others are waiting.
module rr_arb_mux41 #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             ready,
   output logic [3:0]       grant,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] y_data,
   output logic             y_valid,
   output logic             busy
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t     r_state;
   logic [3:0] r_grant;
   logic [1:0] r_sel;
   logic [1:0] r_last;
   logic [3:0] r_hold;

   logic       w_xfer;
   logic       w_rel;
   logic [3:0] w_pend;
   logic [2:0] w_pick;
   logic [4:0] w_hold_inc;

   // Returns {found, index} of the first set bit of m searching from s upward, modulo 4.
   function automatic logic [2:0] f_pick(input logic [3:0] m, input logic [1:0] s);
      logic [2:0] r;
      logic [1:0] idx;
      r = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = s + 2'(k);
         if (m[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   assign w_pend     = req & ~r_grant;
   assign y_valid    = (r_state == S_GRANT) && req[r_sel];
   assign w_xfer     = y_valid && ready;
   assign w_hold_inc = {1'b0, r_hold} + 5'd1;
   // The owner is masked out of the release search, so it cannot immediately re-win.
   assign w_rel      = !req[r_sel] ||
                       (w_xfer && (w_hold_inc >= 5'(MAX_HOLD)) && (w_pend != 4'b0000));
   assign w_pick     = (r_state == S_IDLE) ? f_pick(req, r_last + 2'd1)
                                           : f_pick(w_pend, r_sel + 2'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_grant <= 4'b0000;
         r_sel   <= 2'd0;
         r_last  <= 2'd3;
         r_hold  <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pick[2]) begin
                  r_state <= S_GRANT;
                  r_grant <= 4'b0001 << w_pick[1:0];
                  r_sel   <= w_pick[1:0];
                  r_hold  <= 4'd0;
               end
            end
            S_GRANT: begin
               if (w_rel) begin
                  r_last <= r_sel;
                  if (w_pick[2]) begin
                     r_grant <= 4'b0001 << w_pick[1:0];
                     r_sel   <= w_pick[1:0];
                     r_hold  <= 4'd0;
                  end else begin
                     r_state <= S_IDLE;
                     r_grant <= 4'b0000;
                  end
               end else if (w_xfer) begin
                  r_hold <= (w_hold_inc >= 5'(MAX_HOLD)) ? 4'(MAX_HOLD) : w_hold_inc[3:0];
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      y_data = a;
      case (r_sel)
         2'd0: y_data = a;
         2'd1: y_data = b;
         2'd2: y_data = c;
         2'd3: y_data = d;
         default: y_data = a;
      endcase
   end

   assign grant = r_grant;
   assign sel   = r_sel;
   assign busy  = (r_state == S_GRANT);

endmodule

// File: tb/tb_rr_arb_mux41.sv
// Directed scenarios plus a randomized phase, all checked against an
// integer-level model of owner / budget / round-robin pointer.
module tb_rr_arb_mux41;

   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       req;
   logic [WIDTH-1:0] a, b, c, d;
   logic             ready;
   logic [3:0]       grant;
   logic [1:0]       sel;
   logic [WIDTH-1:0] y_data;
   logic             y_valid;
   logic             busy;

   int checks = 0;
   int errors = 0;

   // model: owner index or -1 when idle, transfers this grant, last owner, select
   int m_own  = -1;
   int m_cnt  = 0;
   int m_last = 3;
   int m_sel  = 0;

   int xq[$];

   rr_arb_mux41 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
      .ready(ready), .grant(grant), .sel(sel), .y_data(y_data),
      .y_valid(y_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr(input logic [3:0] m, input int start);
      for (int k = 0; k < 4; k++) begin
         if (m[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_step();
      logic [3:0] pend;
      bit         xfer, rel;
      int         w;
      if (!rst_n) begin
         m_own = -1; m_cnt = 0; m_last = 3; m_sel = 0;
      end else if (m_own < 0) begin
         w = rr(req, m_last + 1);
         if (w >= 0) begin m_own = w; m_sel = w; m_cnt = 0; end
      end else begin
         xfer = req[m_own] && ready;
         pend = req & ~(4'b0001 << m_own);
         rel  = !req[m_own] || (xfer && (m_cnt + 1 >= MAX_HOLD) && pend != 0);
         if (rel) begin
            m_last = m_own;
            w = rr(pend, m_own + 1);
            if (w >= 0) begin m_own = w; m_sel = w; m_cnt = 0; end
            else m_own = -1;
         end else if (xfer) begin
            m_cnt = (m_cnt + 1 > MAX_HOLD) ? MAX_HOLD : m_cnt + 1;
         end
      end
   endtask

   // Check every output against the model, then advance one clock.
   task automatic tick();
      logic [WIDTH-1:0] ed;
      #1;
      case (m_sel)
         0: ed = a;
         1: ed = b;
         2: ed = c;
         default: ed = d;
      endcase
      chk("m_grant", grant, (m_own < 0) ? 0 : (1 << m_own));
      chk("m_busy", busy, (m_own >= 0));
      chk("m_sel", sel, m_sel);
      chk("m_valid", y_valid, (m_own >= 0) && req[m_own]);
      chk("m_data", y_data, ed);
      if (y_valid && ready) xq.push_back(sel);
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = 4'b0000; ready = 1'b1;
      a = 8'hA5; b = 8'h22; c = 8'h33; d = 8'h44;
      @(posedge clk);
      model_step();
      @(negedge clk);

      // reset state and single request
      do_reset();
      chk("rst_grant", grant, 4'b0000);
      chk("rst_sel", sel, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", y_valid, 1'b0);
      chk("rst_data", y_data, 8'hA5);
      req = 4'b0001;
      tick();
      chk("single_grant", grant, 4'b0001);
      chk("single_sel", sel, 2'd0);
      #1;
      chk("single_data", y_data, 8'hA5);
      chk("single_valid", y_valid, 1'b1);
      req = 4'b0000;
      #1;
      chk("drop_valid", y_valid, 1'b0);
      tick();
      chk("drop_grant", grant, 4'b0000);
      chk("drop_busy", busy, 1'b0);

      // all four requesting: 4 transfers each, in order 0,1,2,3,0
      do_reset();
      a = 8'h11; req = 4'b1111; ready = 1'b1;
      tick();
      xq.delete();
      for (int i = 0; i < 20; i++) begin
         chk("rot_busy", busy, 1'b1);
         tick();
      end
      chk("rot_count", xq.size(), 20);
      for (int i = 0; i < 20 && i < xq.size(); i++) chk("rot_seq", xq[i], (i / 4) % 4);

      // backpressure holds the grant and the budget
      do_reset();
      req = 4'b0011; ready = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("bp_stall", grant, 4'b0001);
      end
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold", grant, 4'b0001);
      end
      tick();
      chk("bp_rotate", grant, 4'b0010);

      // lone requester keeps its grant past the budget
      do_reset();
      req = 4'b0100;
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("lone_keep", grant, 4'b0100);
         tick();
      end
      req = 4'b0101;
      tick();
      chk("lone_rotate", grant, 4'b0001);

      // fairness after owner 2 drops
      do_reset();
      req = 4'b0100;
      tick();
      chk("fair_own2", grant, 4'b0100);
      req = 4'b1001;
      tick();
      chk("fair_next3", grant, 4'b1000);
      for (int i = 0; i < 4; i++) tick();
      chk("fair_then0", grant, 4'b0001);

      // reset in the middle of a transfer
      do_reset();
      req = 4'b0010;
      tick();
      chk("mid_grant", grant, 4'b0010);
      tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_grant", grant, 4'b0000);
      chk("mid_rst_sel", sel, 2'd0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valid", y_valid, 1'b0);
      rst_n = 1'b1; req = 4'b1111;
      tick();
      chk("mid_first", grant, 4'b0001);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         ready = ($urandom_range(0, 3) != 0);
         a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
